mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port node memory (`mem`, 1024 × 16-bit words, 1-cycle synchronous read) among the learning-path requesters: reward computation, Q-value update and the host/packet loader. It sits between those blocks and `mem`, owns `address`/`wr_en`/`data_in` to the memory, and returns read data tagged to the requester. A burst limit keeps the reward engine's long table scans from starving packet loads.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the node-memory port arbiter:
// requester IDs, default sizing and the arbiter state encoding.
package mem_arb_pkg;

  localparam int NUM_REQ           = 3;
  localparam int WORD_WIDTH        = 16;
  localparam int MAX_BURST_DEFAULT = 16;

  localparam int REQ_REWARD  = 0;
  localparam int REQ_QUPDATE = 1;
  localparam int REQ_HOST    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr,
// wrapping, returned one-hot together with a valid flag.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional update, otherwise synthesis infers a latch.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = |req;
    // Walk from the farthest candidate back to rr_ptr so the closest wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single-port node memory with a per-grant burst
// limit; read data comes back one cycle later tagged by rvalid.
module mem_port_arbiter #(
  parameter int NUM_REQ    = mem_arb_pkg::NUM_REQ,
  parameter int WORD_WIDTH = mem_arb_pkg::WORD_WIDTH,
  parameter int MAX_BURST  = mem_arb_pkg::MAX_BURST_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_wr_en,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [WORD_WIDTH-1:0]           rdata,
  output logic [WORD_WIDTH-1:0]           mem_address,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_data_in,
  input  logic [WORD_WIDTH-1:0]           mem_data_out
);

  import mem_arb_pkg::arb_state_e;
  import mem_arb_pkg::ST_IDLE;
  import mem_arb_pkg::ST_OWNED;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;

  logic [NUM_REQ-1:0]    pick_onehot;
  logic                  pick_valid;
  logic [PTR_W-1:0]      pick_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  access;
  logic [WORD_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [WORD_WIDTH-1:0] wdata_arr [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_onehot),
    .valid  (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*WORD_WIDTH +: WORD_WIDTH];
      wdata_arr[i] = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Reset gates the access itself so no write escapes in the reset cycle.
  assign access = (state_q == ST_OWNED) && req[owner_q] && !reset;

  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_wr_en   = 1'b0;
    if (access) begin
      mem_address = addr_arr[owner_q];
      mem_data_in = wdata_arr[owner_q];
      mem_wr_en   = req_wr_en[owner_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    rvalid_d = (access && !req_wr_en[owner_q]) ? gnt_q : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          count_d = '0;
        end
      end
      ST_OWNED: begin
        if (!req[owner_q] || count_q >= CNT_W'(MAX_BURST - 1)) begin
          // Release and burst exhaustion share one path: a single rotation.
          if (access && count_q != CNT_W'(MAX_BURST)) count_d = count_q + 1'b1;
          if (!req[owner_q] || access) begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            rr_ptr_d = next_ptr;
          end
        end else if (access) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt    = gnt_q;
  // A read in flight when reset arrives must never be reported.
  assign rvalid = rvalid_q & {NUM_REQ{~reset}};
  assign rdata  = mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural owner/queue model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int MB = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_addr = '0;
  logic [N-1:0]     req_wr_en = '0;
  logic [N*W-1:0]   req_wdata = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rvalid;
  logic [W-1:0]     rdata;
  logic [W-1:0]     mem_address;
  logic             mem_wr_en;
  logic [W-1:0]     mem_data_in;
  logic [W-1:0]     mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_port_arbiter #(
    .NUM_REQ    (N),
    .WORD_WIDTH (W),
    .MAX_BURST  (MB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_addr     (req_addr),
    .req_wr_en    (req_wr_en),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_address  (mem_address),
    .mem_wr_en    (mem_wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    return (i == 5) ? 16'h00AB : (16'h5000 ^ 16'(i));
  endfunction

  // Bench memory: 1024 x 16, one-cycle synchronous read.
  logic [15:0] mem [1024];
  bit mem_loaded = 0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_loaded <= 1;
    end else if (mem_wr_en) begin
      mem[mem_address[9:0]] <= mem_data_in;
    end
    mem_data_out <= mem[mem_address[9:0]];
  end

  // Requester drivers: hold req while accesses remain, advance after each access.
  int          remaining [N];
  logic [15:0] cur_addr  [N];
  logic [15:0] cur_wdata [N];
  bit          is_wr     [N];
  bit          acc_seen  [N];

  always @(negedge clock)
    for (int i = 0; i < N; i++) acc_seen[i] = gnt[i] && req[i] && !reset;

  initial begin
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0; cur_addr[i] = '0; cur_wdata[i] = '0; is_wr[i] = 0;
    end
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_seen[i] && remaining[i] > 0) begin
          remaining[i]--;
          cur_addr[i]++;
          cur_wdata[i]++;
        end
        req[i]              = remaining[i] > 0;
        req_wr_en[i]        = is_wr[i];
        req_addr[i*W +: W]  = cur_addr[i];
        req_wdata[i*W +: W] = cur_wdata[i];
      end
    end
  end

  // Behavioural model: who owns the port, how many accesses used, whose turn next.
  int          m_owner = -1;
  int          m_cnt   = 0;
  int          m_rr    = 0;
  int          m_pend  = -1;
  logic [15:0] m_pend_data;
  logic [15:0] shadow [1024];
  bit          shadow_loaded = 0;

  always @(negedge clock) begin
    logic [N-1:0] e_gnt, e_rv;
    logic [15:0]  a, d;
    bit           acc, w;
    if (!shadow_loaded) begin
      for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
      shadow_loaded = 1;
    end
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    acc = !reset && m_owner >= 0 && req[m_owner];
    a = '0; d = '0; w = 0;
    if (acc) begin
      a = req_addr[m_owner*W +: W];
      d = req_wdata[m_owner*W +: W];
      w = req_wr_en[m_owner];
    end
    e_rv = '0;
    if (!reset && m_pend >= 0) e_rv[m_pend] = 1'b1;

    check("gnt", 32'(gnt), 32'(e_gnt));
    check("rvalid", 32'(rvalid), 32'(e_rv));
    check("mem_address", 32'(mem_address), 32'(a));
    check("mem_wr_en", 32'(mem_wr_en), 32'(w));
    check("mem_data_in", 32'(mem_data_in), 32'(d));
    if (e_rv != '0) check("rdata", 32'(rdata), 32'(m_pend_data));

    if (reset) begin
      m_owner = -1; m_cnt = 0; m_rr = 0; m_pend = -1;
    end else begin
      m_pend = (acc && !w) ? m_owner : -1;
      if (acc && !w) m_pend_data = shadow[a[9:0]];
      if (acc && w) shadow[a[9:0]] = d;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            m_cnt   = 0;
            break;
          end
        end
      end else if (!req[m_owner]) begin
        m_rr = (m_owner + 1) % N; m_owner = -1;
      end else begin
        m_cnt++;
        if (m_cnt >= MB) begin
          m_rr = (m_owner + 1) % N; m_owner = -1;
        end
      end
    end
  end

  // Monitor: grant-start log and per-requester rvalid tallies.
  int          glog [$];
  int          rv_cnt  [N];
  logic [15:0] last_rd [N];
  logic [N-1:0] prev_gnt = '0;
  initial for (int i = 0; i < N; i++) rv_cnt[i] = 0;
  always @(negedge clock) begin
    if (gnt != '0 && prev_gnt == '0)
      for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
    for (int i = 0; i < N; i++)
      if (rvalid[i]) begin rv_cnt[i]++; last_rd[i] = rdata; end
    prev_gnt = gnt;
  end

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      done = (remaining[0] == 0 && remaining[1] == 0 && remaining[2] == 0 &&
              gnt == '0 && rvalid == '0);
    end
    check(name, 32'(done), 32'd1);
  endtask

  function automatic bit log_match(input int base, input int exp[4], input int len);
    if (glog.size() != base + len) return 0;
    for (int i = 0; i < len; i++) if (glog[base+i] != exp[i]) return 0;
    return 1;
  endfunction

  initial begin
    int base, rq, gc, rc, rv0, rv1, rv2;
    int exp_log [4];
    logic [15:0] rd;

    // Reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);

    // Single read of preloaded word at address 5
    cur_addr[REQ_REWARD] = 16'd5; is_wr[REQ_REWARD] = 0; remaining[REQ_REWARD] = 1;
    rq = -1; gc = -1; rc = -1; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rq < 0 && req[0]) rq = cyc;
      if (gc < 0 && gnt[0]) gc = cyc;
      if (rc < 0 && rvalid[0]) begin rc = cyc; rd = rdata; end
    end
    check("single_gnt_latency", 32'(gc - rq), 32'd1);
    check("single_rvalid_latency", 32'(rc - rq), 32'd2);
    check("single_rdata", 32'(rd), 32'h00AB);
    wait_quiet("single_done");

    // Host writes 0x1234 to 40, then Q-update reads it back
    cur_addr[REQ_HOST] = 16'd40; cur_wdata[REQ_HOST] = 16'h1234;
    is_wr[REQ_HOST] = 1; remaining[REQ_HOST] = 1;
    wait_quiet("write_done");
    check("write_no_rvalid", 32'(rv_cnt[2]), 32'd0);
    rv1 = rv_cnt[1];
    cur_addr[REQ_QUPDATE] = 16'd40; is_wr[REQ_QUPDATE] = 0; remaining[REQ_QUPDATE] = 1;
    wait_quiet("readback_done");
    check("readback_count", 32'(rv_cnt[1] - rv1), 32'd1);
    check("readback_rdata", 32'(last_rd[1]), 32'h1234);

    // Round robin: all three request from reset, two accesses each, 0 returns
    is_wr[2] = 0;
    for (int i = 0; i < N; i++) begin cur_addr[i] = 16'(64 + 8*i); remaining[i] = 2; end
    base = glog.size();
    do_reset();
    for (int k = 0; k < 100 && remaining[0] != 0; k++) @(negedge clock);
    remaining[0] = 2;
    wait_quiet("rr_done");
    exp_log = '{0, 1, 2, 0};
    check("rr_order", 32'(log_match(base, exp_log, 4)), 32'd1);

    // Burst limit: 0 wants 10 reads, 2 wants 4
    do_reset();
    @(negedge clock);
    rv0 = rv_cnt[0]; rv2 = rv_cnt[2]; base = glog.size();
    cur_addr[0] = 16'd100; remaining[0] = 10;
    cur_addr[2] = 16'd200; remaining[2] = 4;
    wait_quiet("burst_done");
    exp_log = '{0, 2, 0, 0};
    check("burst_order", 32'(log_match(base, exp_log, 4)), 32'd1);
    check("burst_rv0", 32'(rv_cnt[0] - rv0), 32'd10);
    check("burst_rv2", 32'(rv_cnt[2] - rv2), 32'd4);

    // Sole requester crossing the burst limit twice
    do_reset();
    @(negedge clock);
    rv1 = rv_cnt[1]; base = glog.size();
    cur_addr[1] = 16'd500; remaining[1] = 9;
    wait_quiet("sole_done");
    exp_log = '{1, 1, 1, 0};
    check("sole_grants", 32'(log_match(base, exp_log, 3)), 32'd1);
    check("sole_rv1", 32'(rv_cnt[1] - rv1), 32'd9);

    // Reset arriving the cycle after a read by requester 0
    do_reset();
    @(negedge clock);
    cur_addr[0] = 16'd300; remaining[0] = 20;
    gc = 0;
    for (int k = 0; k < 20 && !gc; k++) begin
      @(negedge clock);
      gc = int'(gnt[0] && req[0]);
    end
    check("rst_first_access", 32'(gc), 32'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("rst_rvalid_suppressed", 32'(rvalid), 32'd0);
    check("rst_no_write", 32'(mem_wr_en), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rst_gnt_cleared", 32'(gnt), 32'd0);
    rc = 0; rd = '0;
    for (int k = 0; k < 10 && rc == 0; k++) begin
      @(negedge clock);
      if (gnt != '0) begin rc = 1; rd = 16'(gnt); end
    end
    check("rst_next_owner", 32'(rd), 32'd1);
    wait_quiet("rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
